// File: rtl/seq_mul_pkg.sv
// Shared definitions for the sequential signed multiplier: controller state
// encodings and the iteration-counter width helper.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    SM_IDLE = 2'd0,
    SM_RUN  = 2'd1,
    SM_FIX  = 2'd2
  } sm_state_t;

  // Counter must hold the value DATAWIDTH itself, hence the +1.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_mul_if.sv
// Start/busy/done handshake and operand/result bus of the sequential multiplier.
interface seq_mul_if #(
  parameter int DATAWIDTH = 32
);
  logic                 start;
  logic [DATAWIDTH-1:0] a;
  logic [DATAWIDTH-1:0] b;
  logic                 busy;
  logic                 done;
  logic [DATAWIDTH-1:0] p;
  logic                 ovf;

  modport master (output start, a, b, input  busy, done, p, ovf);
  modport slave  (input  start, a, b, output busy, done, p, ovf);
endinterface

// File: rtl/seq_mul.sv
// Sequential signed shift-and-add multiplier: magnitudes are multiplied one
// multiplier bit per cycle, then the sign is applied and overflow judged.
module seq_mul
  import seq_mul_pkg::*;
#(
  parameter int DATAWIDTH = 32
) (
  input logic     clk,
  input logic     rst,
  seq_mul_if.slave bus
);

  localparam int W  = DATAWIDTH;
  localparam int CW = cnt_width(DATAWIDTH);

  sm_state_t       state;
  logic [W-1:0]    mcand;
  logic [W-1:0]    mplier;
  logic [2*W-1:0]  acc;
  logic [CW-1:0]   cnt;
  logic            neg;

  logic [W-1:0]    a_mag;
  logic [W-1:0]    b_mag;
  logic [W-1:0]    addend;
  logic [W:0]      sum;
  logic [2*W-1:0]  full;

  // NOTE: every always_comb output is assigned on every path, so no latches appear.
  always_comb begin
    // Negating -2^(W-1) wraps to itself, which read as unsigned is exactly 2^(W-1).
    a_mag  = bus.a[W-1] ? -bus.a : bus.a;
    b_mag  = bus.b[W-1] ? -bus.b : bus.b;
    addend = mplier[0] ? mcand : '0;
    sum    = {1'b0, acc[2*W-1:W]} + {1'b0, addend};
    full   = neg ? -acc : acc;
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SM_IDLE;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.p    <= '0;
      bus.ovf  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        SM_IDLE: begin
          if (bus.start) begin
            mcand    <= a_mag;
            mplier   <= b_mag;
            neg      <= bus.a[W-1] ^ bus.b[W-1];
            acc      <= '0;
            cnt      <= '0;
            state    <= SM_RUN;
            bus.busy <= 1'b1;
          end
        end
        SM_RUN: begin
          // The add carry lands in the top bit as the accumulator shifts right.
          acc    <= {sum, acc[W-1:1]};
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) state <= SM_FIX;
        end
        SM_FIX: begin
          bus.p    <= full[W-1:0];
          bus.ovf  <= (full[2*W-1:W] != {W{full[W-1]}});
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= SM_IDLE;
        end
        default: state <= SM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul.sv
// Directed and randomized bench for seq_mul at DATAWIDTH=32.
module tb_seq_mul;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;

  seq_mul_if #(.DATAWIDTH(W)) bus ();

  seq_mul #(.DATAWIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one cycle, then waits (bounded) for done. edges is the
  // number of edges after the accepting edge until done is seen (-1 on timeout).
  task automatic run_op(input logic [W-1:0] a_in, input logic [W-1:0] b_in,
                        output logic [W-1:0] p_out, output logic ovf_out,
                        output int edges, output int busy_gaps);
    bus.a = a_in;
    bus.b = b_in;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    edges = -1;
    busy_gaps = (bus.busy !== 1'b1) ? 1 : 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (bus.done === 1'b1) begin
        edges = i;
        break;
      end
      if (bus.busy !== 1'b1) busy_gaps++;
    end
    p_out   = bus.p;
    ovf_out = bus.ovf;
  endtask

  task automatic test_reset();
    int dones;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) tick();
    rst = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    tests_run++;
    if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", bus.done); end
    tests_run++;
    if (bus.p !== 32'h0) begin tests_failed++; $display("FAIL reset_p got %h want 0", bus.p); end
    tests_run++;
    if (bus.ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf got %b want 0", bus.ovf); end
    dones = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.done !== 1'b0) dones++;
    end
    tests_run++;
    if (dones != 0) begin tests_failed++; $display("FAIL reset_idle_done got %0d done cycles want 0", dones); end
  endtask

  task automatic test_basic();
    logic [W-1:0] p;
    logic ovf;
    int edges, gaps;
    run_op(32'd7, -32'sd3, p, ovf, edges, gaps);
    // done appears W+1 edges after the accepting edge: W+2 cycles of latency.
    tests_run++;
    if (edges != W + 1) begin tests_failed++; $display("FAIL basic_latency got %0d edges want %0d", edges, W + 1); end
    tests_run++;
    if (gaps != 0) begin tests_failed++; $display("FAIL basic_busy got %0d low cycles want 0", gaps); end
    tests_run++;
    if (p !== 32'hFFFF_FFEB) begin tests_failed++; $display("FAIL basic_p got %h want ffffffeb", p); end
    tests_run++;
    if (ovf !== 1'b0) begin tests_failed++; $display("FAIL basic_ovf got %b want 0", ovf); end
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL basic_busy_at_done got %b want 0", bus.busy); end
    tick();
    tests_run++;
    if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL basic_done_pulse got %b want 0", bus.done); end
    tests_run++;
    if (bus.p !== 32'hFFFF_FFEB) begin tests_failed++; $display("FAIL basic_p_hold got %h want ffffffeb", bus.p); end
  endtask

  task automatic test_zero();
    logic [W-1:0] za [2] = '{32'hFFFF_FFFF, 32'h0000_0000};
    logic [W-1:0] zb [2] = '{32'h0000_0000, 32'h8000_0000};
    logic [W-1:0] p;
    logic ovf;
    int edges, gaps;
    for (int i = 0; i < 2; i++) begin
      run_op(za[i], zb[i], p, ovf, edges, gaps);
      tests_run++;
      if (edges != W + 1 || p !== 32'h0) begin
        tests_failed++; $display("FAIL zero_p[%0d] got %h (edges %0d) want 0", i, p, edges);
      end
      tests_run++;
      if (ovf !== 1'b0) begin tests_failed++; $display("FAIL zero_ovf[%0d] got %b want 0", i, ovf); end
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] va [8] = '{32'h0001_0000, 32'h8000_0000, 32'd46341,   32'h8000_0000,
                             32'hFFFF_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [W-1:0] vb [8] = '{32'h0001_0000, 32'hFFFF_FFFF, 32'd46341,   32'h0000_0001,
                             32'h0000_8000, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [W-1:0] ep [8] = '{32'h0000_0000, 32'h8000_0000, 32'h8000_1219, 32'h8000_0000,
                             32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001};
    logic         eo [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [W-1:0] p;
    logic ovf;
    int edges, gaps;
    for (int i = 0; i < 8; i++) begin
      run_op(va[i], vb[i], p, ovf, edges, gaps);
      tests_run++;
      if (edges != W + 1 || p !== ep[i]) begin
        tests_failed++; $display("FAIL ovf_case_p[%0d] got %h (edges %0d) want %h", i, p, edges, ep[i]);
      end
      tests_run++;
      if (ovf !== eo[i]) begin tests_failed++; $display("FAIL ovf_case_flag[%0d] got %b want %b", i, ovf, eo[i]); end
    end
  endtask

  // start stays high throughout; only operands present on accepting edges count.
  task automatic test_start_held();
    int edges;
    bus.start = 1'b1;
    bus.a = 32'd3;
    bus.b = 32'd5;
    tick();
    edges = -1;
    for (int i = 1; i <= 100; i++) begin
      bus.a = 32'(i * 7 + 1);
      bus.b = -32'(i);
      tick();
      if (bus.done === 1'b1) begin edges = i; break; end
    end
    tests_run++;
    if (edges != W + 1 || bus.p !== 32'd15) begin
      tests_failed++; $display("FAIL held_first got %h (edges %0d) want 0000000f", bus.p, edges);
    end
    bus.a = -32'sd4;
    bus.b = 32'd6;
    edges = -1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      bus.a = 32'(i * 13);
      bus.b = 32'(i + 2);
      if (bus.done === 1'b1) begin edges = i; break; end
    end
    bus.start = 1'b0;
    tests_run++;
    if (edges != W + 2) begin tests_failed++; $display("FAIL held_interval got %0d edges want %0d", edges, W + 2); end
    tests_run++;
    if (bus.p !== 32'hFFFF_FFE8 || bus.ovf !== 1'b0) begin
      tests_failed++; $display("FAIL held_second got %h/%b want ffffffe8/0", bus.p, bus.ovf);
    end
    tick();
  endtask

  // Each new op is launched in the done cycle of the previous one.
  task automatic test_back_to_back();
    logic [W-1:0] ba [3] = '{32'd100,       -32'sd12345,   32'h4000_0000};
    logic [W-1:0] bb [3] = '{-32'sd100,     -32'sd2,       32'd2};
    logic [W-1:0] ep [3] = '{32'hFFFF_D8F0, 32'h0000_6072, 32'h8000_0000};
    logic         eo [3] = '{1'b0, 1'b0, 1'b1};
    int edges;
    bus.a = ba[0];
    bus.b = bb[0];
    bus.start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      bus.start = 1'b0;
      edges = -1;
      for (int i = 1; i <= 100; i++) begin
        tick();
        if (bus.done === 1'b1) begin edges = i; break; end
      end
      tests_run++;
      if (edges != W + 1) begin tests_failed++; $display("FAIL b2b_latency[%0d] got %0d edges want %0d", k, edges, W + 1); end
      tests_run++;
      if (bus.p !== ep[k] || bus.ovf !== eo[k]) begin
        tests_failed++; $display("FAIL b2b_result[%0d] got %h/%b want %h/%b", k, bus.p, bus.ovf, ep[k], eo[k]);
      end
      if (k < 2) begin
        bus.a = ba[k+1];
        bus.b = bb[k+1];
        bus.start = 1'b1;
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int dones;
    bus.a = 32'd9;
    bus.b = 32'd9;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      tests_failed++; $display("FAIL midrst_ctrl got busy %b done %b want 0 0", bus.busy, bus.done);
    end
    tests_run++;
    if (bus.p !== 32'h0 || bus.ovf !== 1'b0) begin
      tests_failed++; $display("FAIL midrst_out got %h/%b want 0/0", bus.p, bus.ovf);
    end
    dones = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) dones++;
    end
    tests_run++;
    if (dones != 0) begin tests_failed++; $display("FAIL midrst_quiet got %0d active cycles want 0", dones); end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, p, exp_p;
    logic ovf, exp_ovf;
    longint prod;
    int edges, gaps;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 2 == 1) a = 32'($signed(a) >>> $urandom_range(31, 0));
      if (i % 3 == 1) b = 32'($signed(b) >>> $urandom_range(31, 0));
      prod    = longint'($signed(a)) * longint'($signed(b));
      exp_p   = prod[31:0];
      exp_ovf = (prod > 64'sd2147483647) || (prod < -64'sd2147483648);
      run_op(a, b, p, ovf, edges, gaps);
      tests_run++;
      if (edges != W + 1 || p !== exp_p) begin
        tests_failed++; $display("FAIL rand_p %h*%h got %h (edges %0d) want %h", a, b, p, edges, exp_p);
      end
      tests_run++;
      if (ovf !== exp_ovf) begin
        tests_failed++; $display("FAIL rand_ovf %h*%h got %b want %b", a, b, ovf, exp_ovf);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    test_reset();
    test_basic();
    test_zero();
    test_overflow();
    test_start_held();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
